store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
Multicycle store engine that generalises the word/half/byte store mask for the datapath.
- Accepts a store request: address, store data (B) and size.
- Sub-word stores run a read-modify-write: read the containing memory word, merge the store bytes into the addressed lane, write the word back.
- Full-width stores skip the read.
- Sits between the control unit and the data memory, with a start/busy/done handshake and a misalignment exception output.

Parameters:
- DATA_W, 32, memory word width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- MEM_RD_LAT, 1, cycles from mem_addr valid to mem_rdata valid; must be ≥ 1.
- ALIGN_LANES, 1, 1 = place byte/half data in the lane selected by the low address bits and check alignment; 0 = legacy mode, always lane 0, no alignment check.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- size  in  2  00 full word, 01 half, 10 byte, 11 full word.
- addr  in  ADDR_W  byte address of the store.
- wdata  in  DATA_W  store data; the byte/half payload is in its low bits.
- mem_rdata  in  DATA_W  memory read data.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  DATA_W  merged write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the store has completed.
- misaligned_exc  out  1  one-cycle pulse; the store was rejected.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, done=0, misaligned_exc=0; FSM in IDLE.
- Definitions: OFFB = log2(DATA_W/8) low address bits. mem_addr = addr_q with OFFB low bits cleared.
- Request capture: in IDLE with start=1, addr, size and wdata are registered (addr_q, size_q, wdata_q) at that edge (cycle 0).
- start while busy=1 is ignored and never queued.
- FSM states:
  - IDLE: start=1 and misaligned → ERR; start=1 and full word → WRITE; start=1 and half/byte → READ with the counter loaded with MEM_RD_LAT−1.
  - READ: mem_addr driven and held stable; count down; at count 0 → WRITE.
  - WRITE: mem_wr=1 for exactly one cycle → DONE.
  - DONE: done=1 → IDLE.
  - ERR: misaligned_exc=1, no memory access → IDLE.
- Misaligned (ALIGN_LANES=1 only): half with addr[0]=1, or full word with addr[OFFB-1:0]≠0. Byte stores are never misaligned.
- Merge, in WRITE:
  - Full word: mem_wdata = wdata_q.
  - Byte: mem_wdata = mem_rdata with byte lane L replaced by wdata_q[7:0]. L = addr_q[OFFB-1:0], or 0 when ALIGN_LANES=0.
  - Half: mem_wdata = mem_rdata with half lane H replaced by wdata_q[15:0]. H = addr_q[OFFB-1:1], or 0 when ALIGN_LANES=0.
  - Lanes are little-endian: lane 0 = bits [7:0].
- mem_rdata is sampled combinationally during WRITE. Memory holds it valid MEM_RD_LAT cycles after mem_addr is first presented, which is the WRITE cycle.
- Latency:
  - Full word: mem_wr in cycle 1, done in cycle 2, next start accepted in cycle 3.
  - Sub-word: mem_wr in cycle 1+MEM_RD_LAT, done in cycle 2+MEM_RD_LAT.
  - Misaligned: misaligned_exc in cycle 1, IDLE in cycle 2.
- mem_addr is valid from cycle 1 through WRITE. Its value outside READ/WRITE is don't-care but held.
- Reset in any state: next edge enters IDLE and clears all outputs. A store interrupted in READ never issues mem_wr. done and misaligned_exc are never both high.

Decomposition:
- Shared package store_pkg holds:
  - size codes SZ_WORD, SZ_HALF, SZ_BYTE, SZ_WORD_ALT;
  - the FSM state encoding (IDLE, READ, WRITE, DONE, ERR);
  - a lane-count constant derived from DATA_W.
- One combinational sub-module, lane_merge, computes the merge from (old word, new data, size, lane offset, ALIGN_LANES).
- The FSM, counter and request registers stay in store_merge_unit.

Test Plan:
- DATA_W=32, MEM_RD_LAT=1; byte store, addr=0x101, wdata=0x12345678, mem word=0xAABBCCDD → mem_addr=0x100; mem_wr in cycle 2 with mem_wdata=0xAABB78DD; done in cycle 3.
- Half store, addr=0x102, wdata=0x12345678, mem=0xAABBCCDD → mem_wdata=0x5678CCDD. Same store at addr=0x103 → misaligned_exc in cycle 1, no mem_wr, no done.
- Word store, addr=0x04, wdata=0xDEADBEEF → mem_wr in cycle 1 with mem_wdata=0xDEADBEEF and no READ; done in cycle 2. start pulsed in cycle 1 → ignored.
- ALIGN_LANES=0, byte store, addr=0x3, wdata=0x12345678, mem=0xAABBCCDD → mem_wdata=0xAABBCC78; the same addr as a word store → no exception.
- MEM_RD_LAT=3, byte store, reset asserted in cycle 2 → all outputs 0 in cycle 3, no mem_wr, no done. A fresh word store started in cycle 3 completes normally.
- DATA_W=64, half store, addr=0x6, wdata=0xBEEF, mem=0x1122334455667788 → mem_wdata=0xBEEF334455667788.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store merge engine.
// Holds the store size codes, the FSM state encoding and small helpers that
// derive lane geometry from the memory word width.
package store_pkg;

  // Store size codes as presented on the size input.
  localparam logic [1:0] SZ_WORD     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_BYTE     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  // FSM state encoding.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  // Number of byte lanes in a memory word.
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Number of low address bits selecting a byte within a memory word (OFFB).
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Both 00 and 11 encode a full-width store.
  function automatic logic is_full_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == SZ_WORD_ALT);
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// lane_merge: combinational byte/half/word merge of store data into a memory word.
// Ports:
//   old_word  - word read back from memory
//   new_data  - store data; byte/half payload sits in the low bits
//   size      - store size code
//   lane      - byte offset of the store within the word (addr low bits)
//   merged    - resulting word to write back
// With ALIGN_LANES=0 the lane offset is ignored and sub-word data lands in lane 0.
module lane_merge
  import store_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ALIGN_LANES = 1,
  localparam int OFFB       = lane_bits(DATA_W)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [1:0]        size,
  input  logic [OFFB-1:0]   lane,
  output logic [DATA_W-1:0] merged
);

  localparam int LANES = lane_count(DATA_W);

  logic [OFFB-1:0] eff_lane;

  assign eff_lane = (ALIGN_LANES != 0) ? lane : '0;

  always_comb begin
    // NOTE: merged is given a full default before any conditional overwrite,
    // so every path assigns it and no latch is inferred.
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (is_full_word(size)) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end else if (size == SZ_BYTE) begin
        if (OFFB'(i) == eff_lane) merged[8*i +: 8] = new_data[7:0];
      end else begin
        // Half lane H covers byte lanes 2H and 2H+1; low byte goes in the even lane.
        if ((OFFB'(i) >> 1) == (eff_lane >> 1))
          merged[8*i +: 8] = (i % 2 == 1) ? new_data[15:8] : new_data[7:0];
      end
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: multicycle store engine between control unit and data memory.
// Full-width stores write directly; byte/half stores read the containing word,
// merge the payload into the addressed lane and write the word back.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - request strobe, honoured only while idle
//   size/addr/wdata - store request (size code, byte address, data)
//   mem_rdata       - memory read data, valid in the WRITE cycle
//   mem_addr        - word-aligned memory address
//   mem_wr          - one-cycle memory write enable
//   mem_wdata       - merged write data (0 outside WRITE)
//   busy            - high whenever not idle
//   done            - one-cycle completion pulse
//   misaligned_exc  - one-cycle pulse, store rejected without memory access
module store_merge_unit
  import store_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_RD_LAT  = 1,
  parameter int ALIGN_LANES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned_exc
);

  localparam int OFFB  = lane_bits(DATA_W);
  localparam int CNT_W = $clog2(MEM_RD_LAT) + 1;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mis;
  logic [DATA_W-1:0] merged;

  // Alignment check on the incoming request; byte stores always pass.
  always_comb begin
    mis = 1'b0;
    if (ALIGN_LANES != 0) begin
      if (size == SZ_HALF)         mis = addr[0];
      else if (is_full_word(size)) mis = |addr[OFFB-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the request registers are reset (not just the FSM) because
      // mem_addr is derived from addr_q and must read 0 after reset.
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            size_q  <= size;
            wdata_q <= wdata;
            cnt     <= CNT_W'(MEM_RD_LAT - 1);
            if (mis)                     state <= ERR;
            else if (is_full_word(size)) state <= WRITE;
            else                         state <= READ;
          end
        end
        // Hold the address while memory produces the read data.
        READ: begin
          if (cnt == '0) state <= WRITE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        WRITE:   state <= DONE;
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  lane_merge #(
    .DATA_W      (DATA_W),
    .ALIGN_LANES (ALIGN_LANES)
  ) u_lane_merge (
    .old_word (mem_rdata),
    .new_data (wdata_q),
    .size     (size_q),
    .lane     (addr_q[OFFB-1:0]),
    .merged   (merged)
  );

  assign mem_addr       = {addr_q[ADDR_W-1:OFFB], OFFB'(0)};
  assign mem_wr         = (state == WRITE);
  assign mem_wdata      = (state == WRITE) ? merged : '0;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign misaligned_exc = (state == ERR);

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit. Four instances cover the
// configurations of interest:
//   d0: 32-bit, read latency 1, aligned lanes
//   d1: 32-bit, read latency 3, aligned lanes
//   d2: 32-bit, read latency 1, legacy lane 0
//   d3: 64-bit, read latency 2, aligned lanes
// A small word memory per instance feeds mem_rdata; the expected write data,
// timing and exceptions come from a plain arithmetic model of the store rules.
module tb_store_merge_unit;

  logic                  clk;
  logic [3:0]            rst;
  logic [3:0]            start;
  logic [3:0][1:0]       size;
  logic [3:0][31:0]      addr;
  logic [3:0][63:0]      wdata;
  logic [3:0][63:0]      rdata;
  logic [3:0][31:0]      maddr;
  logic [3:0]            mwr;
  logic [3:0][63:0]      mwd;
  logic [3:0]            busy;
  logic [3:0]            done;
  logic [3:0]            exc;

  logic [63:0] memw    [4][16];
  logic [63:0] last_wr [4];
  int          wr_cnt  [4];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_RD_LAT(1), .ALIGN_LANES(1)) u_d0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0][31:0]), .mem_rdata(rdata[0][31:0]), .mem_addr(maddr[0]),
    .mem_wr(mwr[0]), .mem_wdata(mwd[0][31:0]), .busy(busy[0]), .done(done[0]),
    .misaligned_exc(exc[0]));

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_RD_LAT(3), .ALIGN_LANES(1)) u_d1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1][31:0]), .mem_rdata(rdata[1][31:0]), .mem_addr(maddr[1]),
    .mem_wr(mwr[1]), .mem_wdata(mwd[1][31:0]), .busy(busy[1]), .done(done[1]),
    .misaligned_exc(exc[1]));

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_RD_LAT(1), .ALIGN_LANES(0)) u_d2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .size(size[2]), .addr(addr[2]),
    .wdata(wdata[2][31:0]), .mem_rdata(rdata[2][31:0]), .mem_addr(maddr[2]),
    .mem_wr(mwr[2]), .mem_wdata(mwd[2][31:0]), .busy(busy[2]), .done(done[2]),
    .misaligned_exc(exc[2]));

  store_merge_unit #(.DATA_W(64), .ADDR_W(32), .MEM_RD_LAT(2), .ALIGN_LANES(1)) u_d3 (
    .clk(clk), .reset(rst[3]), .start(start[3]), .size(size[3]), .addr(addr[3]),
    .wdata(wdata[3]), .mem_rdata(rdata[3]), .mem_addr(maddr[3]),
    .mem_wr(mwr[3]), .mem_wdata(mwd[3]), .busy(busy[3]), .done(done[3]),
    .misaligned_exc(exc[3]));

  assign mwd[0][63:32] = '0;
  assign mwd[1][63:32] = '0;
  assign mwd[2][63:32] = '0;

  // ---------------- configuration helpers ----------------
  function automatic int dw_of(input int d);
    return (d == 3) ? 64 : 32;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 1) ? 3 : (d == 3) ? 2 : 1;
  endfunction

  function automatic bit al_of(input int d);
    return d != 2;
  endfunction

  function automatic logic [63:0] mask_of(input int d);
    return (dw_of(d) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int idx_of(input int d, input logic [31:0] a);
    return int'((a / (dw_of(d) / 8)) % 16);
  endfunction

  // Memory returns the word at the presented address.
  always_comb begin
    rdata = '0;
    for (int d = 0; d < 4; d++) rdata[d] = memw[d][idx_of(d, maddr[d])];
  end

  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (mwr[d]) begin
        last_wr[d] <= mwd[d];
        wr_cnt[d]  <= wr_cnt[d] + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_mis(input int d, input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = dw_of(d) / 8;
    if (!al_of(d)) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz == 2'b00 || sz == 2'b11) return (a % nb) != 0;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_merge(input int d, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [63:0] wd,
                                              input logic [63:0] old);
    int nb, sh;
    logic [63:0] r;
    nb = dw_of(d) / 8;
    if (sz == 2'b00 || sz == 2'b11) return wd & mask_of(d);
    if (sz == 2'b10) begin
      sh = al_of(d) ? 8 * int'(a % nb) : 0;
      r  = (old & ~(64'hFF << sh)) | ((wd & 64'hFF) << sh);
    end else begin
      sh = al_of(d) ? 16 * (int'(a % nb) / 2) : 0;
      r  = (old & ~(64'hFFFF << sh)) | ((wd & 64'hFFFF) << sh);
    end
    return r & mask_of(d);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int d, input logic [31:0] a, input logic [63:0] v);
    memw[d][idx_of(d, a)] = v & mask_of(d);
  endtask

  // Issue one store on instance d, starting at a negedge, and check every
  // cycle through the first idle cycle. Returns at a negedge with the unit idle.
  // poke=1 raises start with a different request while the unit is busy.
  task automatic run_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                           input logic [63:0] wd, input bit poke);
    int nb, wr_c, done_c, idx;
    bit mis, full;
    logic [63:0] exp;
    logic [31:0] waddr;
    nb     = dw_of(d) / 8;
    mis    = model_mis(d, sz, a);
    full   = (sz == 2'b00) || (sz == 2'b11);
    idx    = idx_of(d, a);
    exp    = model_merge(d, sz, a, wd, memw[d][idx]);
    waddr  = a - (a % nb);
    wr_c   = full ? 1 : 1 + lat_of(d);
    done_c = wr_c + 1;

    start[d] = 1'b1;
    size[d]  = sz;
    addr[d]  = a;
    wdata[d] = wd & mask_of(d);
    @(posedge clk);

    if (mis) begin
      @(negedge clk);
      start[d] = 1'b0;
      check($sformatf("d%0d exc c1", d),  {63'd0, exc[d]},  64'd1);
      check($sformatf("d%0d busy c1", d), {63'd0, busy[d]}, 64'd1);
      check($sformatf("d%0d wr c1", d),   {63'd0, mwr[d]},  64'd0);
      check($sformatf("d%0d done c1", d), {63'd0, done[d]}, 64'd0);
      @(negedge clk);
      check($sformatf("d%0d exc c2", d),  {63'd0, exc[d]},  64'd0);
      check($sformatf("d%0d busy c2", d), {63'd0, busy[d]}, 64'd0);
      return;
    end

    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      check($sformatf("d%0d busy c%0d", d, c), {63'd0, busy[d]}, {63'd0, c <= done_c});
      check($sformatf("d%0d wr c%0d", d, c),   {63'd0, mwr[d]},  {63'd0, c == wr_c});
      check($sformatf("d%0d done c%0d", d, c), {63'd0, done[d]}, {63'd0, c == done_c});
      check($sformatf("d%0d exc c%0d", d, c),  {63'd0, exc[d]},  64'd0);
      if (c <= wr_c)
        check($sformatf("d%0d maddr c%0d", d, c), {32'd0, maddr[d]}, {32'd0, waddr});
      if (c == wr_c)
        check($sformatf("d%0d wdata c%0d", d, c), mwd[d], exp);
      if (c == 1 && poke) begin
        start[d] = 1'b1;
        size[d]  = ~sz;
        addr[d]  = a ^ 32'h5;
      end else begin
        start[d] = 1'b0;
      end
    end
    memw[d][idx] = exp;
  endtask

  // Watchdog: the sequence below is fixed-length, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int wc;
    vectors     = 0;
    miscompares = 0;
    rst   = 4'hF;
    start = '0;
    size  = '0;
    addr  = '0;
    wdata = '0;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 16; i++) memw[d][i] = {$urandom, $urandom} & mask_of(d);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("d%0d rst maddr", d), {32'd0, maddr[d]}, 64'd0);
      check($sformatf("d%0d rst wr", d),    {63'd0, mwr[d]},   64'd0);
      check($sformatf("d%0d rst wdata", d), mwd[d],            64'd0);
      check($sformatf("d%0d rst busy", d),  {63'd0, busy[d]},  64'd0);
      check($sformatf("d%0d rst done", d),  {63'd0, done[d]},  64'd0);
      check($sformatf("d%0d rst exc", d),   {63'd0, exc[d]},   64'd0);
    end
    rst = 4'h0;
    @(negedge clk);

    // Byte store into lane 1.
    set_word(0, 32'h100, 64'hAABBCCDD);
    run_store(0, 2'b10, 32'h101, 64'h12345678, 1'b0);
    check("tp byte result", last_wr[0], 64'hAABB78DD);

    // Half store into upper half, then a misaligned half.
    set_word(0, 32'h100, 64'hAABBCCDD);
    run_store(0, 2'b01, 32'h102, 64'h12345678, 1'b0);
    check("tp half result", last_wr[0], 64'h5678CCDD);
    wc = wr_cnt[0];
    run_store(0, 2'b01, 32'h103, 64'h12345678, 1'b0);
    check("tp misaligned no write", 64'(wr_cnt[0]), 64'(wc));

    // Full word with a start pulse while busy.
    wc = wr_cnt[0];
    run_store(0, 2'b00, 32'h004, 64'hDEADBEEF, 1'b1);
    check("tp word result", last_wr[0], 64'hDEADBEEF);
    check("tp word single write", 64'(wr_cnt[0]), 64'(wc + 1));

    // Legacy lane mode: byte always lane 0, word at odd address accepted.
    set_word(2, 32'h000, 64'hAABBCCDD);
    run_store(2, 2'b10, 32'h003, 64'h12345678, 1'b0);
    check("tp legacy byte", last_wr[2], 64'hAABBCC78);
    run_store(2, 2'b11, 32'h003, 64'hCAFEF00D, 1'b0);
    check("tp legacy word", last_wr[2], 64'hCAFEF00D);

    // 64-bit half store into half lane 3.
    set_word(3, 32'h000, 64'h1122334455667788);
    run_store(3, 2'b01, 32'h006, 64'hBEEF, 1'b0);
    check("tp 64b half", last_wr[3], 64'hBEEF334455667788);

    // Reset in the middle of a long read: no write, no done, clean restart.
    wc = wr_cnt[1];
    start[1] = 1'b1;
    size[1]  = 2'b10;
    addr[1]  = 32'h021;
    wdata[1] = 64'h5A;
    @(posedge clk);
    @(negedge clk);
    start[1] = 1'b0;
    check("d1 rstmid busy c1", {63'd0, busy[1]}, 64'd1);
    @(negedge clk);
    check("d1 rstmid wr c2", {63'd0, mwr[1]}, 64'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("d1 rstmid busy c3",  {63'd0, busy[1]}, 64'd0);
    check("d1 rstmid wr c3",    {63'd0, mwr[1]},  64'd0);
    check("d1 rstmid done c3",  {63'd0, done[1]}, 64'd0);
    check("d1 rstmid exc c3",   {63'd0, exc[1]},  64'd0);
    check("d1 rstmid maddr c3", {32'd0, maddr[1]}, 64'd0);
    check("d1 rstmid wdata c3", mwd[1], 64'd0);
    run_store(1, 2'b00, 32'h024, 64'h0BADF00D, 1'b0);
    check("d1 rstmid writes", 64'(wr_cnt[1]), 64'(wc + 1));
    check("d1 restart result", last_wr[1], 64'h0BADF00D);

    // Randomized stores across all configurations.
    for (int n = 0; n < 60; n++) begin
      int d;
      d = int'($urandom_range(0, 3));
      run_store(d, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)),
                {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
